// File: rtl/csa_final_adder.sv
// Two-stage final adder that resolves a carry-save (sum, carry) pair into a binary sum.
// Stage 1 adds the low half; stage 2 adds the high half with the registered low-half carry.
module csa_final_adder #(
  parameter int WIDTH = 64
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] ca_in,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] res
);

  localparam int H = WIDTH / 2;

  if ((WIDTH % 2) != 0 || WIDTH < 8) begin : g_width_check
    $error("csa_final_adder: WIDTH must be even and at least 8");
  end

  // Handshake: a transfer happens on a rising edge only when the valid and
  // ready of that side are both high; flush overrides every transfer.
  logic           s1_vld;
  logic           s2_vld;
  logic           s1_c;
  logic [H-1:0]   s1_lo;
  logic [H-1:0]   s1_s_hi;
  logic [H-1:0]   s1_ca_hi;
  logic [WIDTH-1:0] res_q;

  logic           s2_adv;
  logic           s1_adv;
  logic           in_fire;
  logic [H:0]     lo_sum;
  logic [H-1:0]   hi_sum;
  logic           unused_ca_msb;

  assign s2_adv  = !s2_vld || out_rdy;
  assign s1_adv  = s1_vld && s2_adv;
  assign in_rdy  = !flush && (!s1_vld || s1_adv);
  assign in_fire = in_vld && in_rdy;

  // The carry vector is shifted left by one: its top bit falls off the result.
  assign unused_ca_msb = ca_in[WIDTH-1];
  assign lo_sum = {1'b0, s_in[H-1:0]} + {1'b0, ca_in[H-2:0], 1'b0};
  assign hi_sum = s1_s_hi + s1_ca_hi + {{(H-1){1'b0}}, s1_c};

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      res_q  <= '0;
    end else if (flush) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_vld <= 1'b1;
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end
      if (s2_adv) begin
        s2_vld <= s1_vld;
      end
      if (s1_adv) begin
        res_q <= {hi_sum, s1_lo};
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (in_fire) begin
      s1_lo    <= lo_sum[H-1:0];
      s1_c     <= lo_sum[H];
      s1_s_hi  <= s_in[WIDTH-1:H];
      s1_ca_hi <= ca_in[WIDTH-2:H-1];
    end
  end

  assign out_vld = s2_vld;
  assign res     = res_q;

endmodule
